// File: rtl/and_gate_if.sv
// and_gate_if: operand/result bundle for and_gate.
// Signals: A, B (operands, driven by master); Y (combinational A&B); Y_q, all_one,
//          any_one (registered, 1-cycle); hi_cnt (only when AND_GATE_STATS_EN is defined).
interface and_gate_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Y_q;
   logic             all_one;
   logic             any_one;
`ifdef AND_GATE_STATS_EN
   logic [CNT_W-1:0] hi_cnt;

   modport master (output A, B, input Y, Y_q, all_one, any_one, hi_cnt);
   modport slave  (input A, B, output Y, Y_q, all_one, any_one, hi_cnt);
`else
   modport master (output A, B, input Y, Y_q, all_one, any_one);
   modport slave  (input A, B, output Y, Y_q, all_one, any_one);
`endif

   // Reject illegal widths at elaboration rather than producing odd hardware.
   if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
      $error("and_gate_if: WIDTH must be 1..64 and CNT_W >= 1");
   end
endinterface

// File: rtl/and_gate.sv
// and_gate: bitwise 2-input AND with a registered copy, reduction flags and an
//           optional saturating activity counter (enabled by macro AND_GATE_STATS_EN).
// Ports: clk, rst_n (synchronous, active-low); bus.slave carries A, B in and
//        Y (0-cycle), Y_q / all_one / any_one (1-cycle), hi_cnt (stats build only) out.
module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   and_gate_if.slave bus
);

   if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
      $error("and_gate: WIDTH must be 1..64 and CNT_W >= 1");
   end

   // Combinational path: independent of clk and rst_n, X/Z follow plain '&'.
   assign bus.Y = bus.A & bus.B;

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_q;
   logic             all_one_d;
   logic             all_one_q;
   logic             any_one_d;
   logic             any_one_q;

   // Flags are computed from the same A&B that Y_q captures, so all three
   // registered outputs line up on the same cycle.
   always_comb begin
      y_d       = bus.A & bus.B;
      all_one_d = &y_d;
      any_one_d = |y_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q       <= '0;
         all_one_q <= 1'b0;
         any_one_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         all_one_q <= all_one_d;
         any_one_q <= any_one_d;
      end
   end

   assign bus.Y_q     = y_q;
   assign bus.all_one = all_one_q;
   assign bus.any_one = any_one_q;

`ifdef AND_GATE_STATS_EN
   logic [CNT_W-1:0] hi_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q;

   // Count cycles with a non-zero result; stick at all-ones instead of wrapping.
   always_comb begin
      hi_cnt_d = hi_cnt_q;
      if (any_one_d && (hi_cnt_q != {CNT_W{1'b1}})) begin
         hi_cnt_d = hi_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_cnt_q <= '0;
      end else begin
         hi_cnt_q <= hi_cnt_d;
      end
   end

   assign bus.hi_cnt = hi_cnt_q;
`endif

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

   localparam int W     = 8;
   localparam int CNT_W = 3;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic clk_idle = 1'b0;
   logic rst_idle = 1'b1;

   int nchk  = 0;
   int nfail = 0;

   // Reference model state.
   logic [W-1:0]     m_q   = '0;
   int               m_cnt = 0;
   logic [W-1:0]     exp_y;
   logic [W-1:0]     xpat;

   and_gate_if #(.WIDTH(W), .CNT_W(CNT_W)) bus8 ();
   and_gate_if #(.WIDTH(1), .CNT_W(CNT_W)) bus1 ();

   and_gate #(.WIDTH(W), .CNT_W(CNT_W)) u_w8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   // Width-1 instance with its clock held still: only the combinational path is exercised.
   and_gate #(.WIDTH(1), .CNT_W(CNT_W)) u_w1 (
      .clk   (clk_idle),
      .rst_n (rst_idle),
      .bus   (bus1.slave)
   );

   initial forever #5 clk = ~clk;

   // Per-bit truth table applied with arithmetic: a result bit is 1 only when both bits are 1.
   function automatic logic [W-1:0] ref_and(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[i] = ((int'(a[i]) + int'(b[i])) == 2);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive operands, check Y immediately, then check registered outputs after the edge.
   task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic rst);
      bus8.A = a;
      bus8.B = b;
      rst_n  = rst;
      #1;
      exp_y = ref_and(a, b);
      check("y_comb", 64'(bus8.Y), 64'(exp_y));
      @(posedge clk);
      #1;
      if (!rst) begin
         m_q   = '0;
         m_cnt = 0;
      end else begin
         m_q = exp_y;
         if (exp_y != 0 && m_cnt < (2**CNT_W - 1)) m_cnt++;
      end
      check("y_q",     64'(bus8.Y_q),     64'(m_q));
      check("all_one", 64'(bus8.all_one), 64'(m_q == {W{1'b1}}));
      check("any_one", 64'(bus8.any_one), 64'(m_q != 0));
`ifdef AND_GATE_STATS_EN
      check("hi_cnt",  64'(bus8.hi_cnt),  64'(m_cnt));
`endif
   endtask

   initial begin
      logic [W-1:0] ra, rb;

      // Width-1 truth table with no clock running.
      for (int i = 0; i < 4; i++) begin
         bus1.A = i[1];
         bus1.B = i[0];
         #1;
         check("w1_truth", 64'(bus1.Y), 64'(i == 3));
         #9;
      end

      // Reset state: registered outputs cleared while Y tracks the inputs.
      step(8'hA5, 8'hFF, 1'b0);
      check("rst_y_q", 64'(bus8.Y_q), 64'h0);

      // F0 & 3C.
      step(8'hF0, 8'h3C, 1'b1);
      check("f0_3c_y_q", 64'(bus8.Y_q), 64'h30);
      check("f0_3c_any", 64'(bus8.any_one), 64'h1);
      check("f0_3c_all", 64'(bus8.all_one), 64'h0);

      // All ones, then A=0.
      step(8'hFF, 8'hFF, 1'b1);
      check("ff_all", 64'(bus8.all_one), 64'h1);
      step(8'h00, 8'hFF, 1'b1);
      check("zero_any", 64'(bus8.any_one), 64'h0);

      // X propagation: a 0 dominates, 1&X stays X.
      bus8.A = 8'h0F;
      bus8.B = 8'bxxxx_0000;
      #1;
      check("x_zero_dom", 64'(bus8.Y), 64'h0);
      bus8.A = 8'hFF;
      #1;
      xpat = 8'bxxxx_0000;
      check("x_prop", 64'(bus8.Y), 64'(xpat));

      // Reset held for two cycles with A=B=1, then release.
      step(8'h01, 8'h01, 1'b0);
      step(8'h01, 8'h01, 1'b0);
      check("rst_hold_any", 64'(bus8.any_one), 64'h0);
      step(8'h01, 8'h01, 1'b1);
      check("release_y_q", 64'(bus8.Y_q), 64'h1);

      // Counter saturation: reset, then 10 busy cycles.
      step(8'h01, 8'h01, 1'b0);
      for (int i = 0; i < 10; i++) step(8'h01, 8'h01, 1'b1);
`ifdef AND_GATE_STATS_EN
      check("cnt_sat", 64'(bus8.hi_cnt), 64'd7);
`endif
      step(8'h01, 8'h01, 1'b0);
`ifdef AND_GATE_STATS_EN
      check("cnt_rst", 64'(bus8.hi_cnt), 64'd0);
`endif
      // B toggling for six cycles: three active cycles.
      for (int i = 0; i < 6; i++) step(8'h01, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b1);
`ifdef AND_GATE_STATS_EN
      check("cnt_toggle", 64'(bus8.hi_cnt), 64'd3);
`endif

      // Random operands with occasional resets; all-ones biased in to hit all_one.
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         step(ra, rb, ($urandom_range(0, 15) != 0));
      end

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
